// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer priority pixel compositor with round/overlay state machine (option: LAYER_COMPOSITOR_BLINK_EN)
module layer_compositor #(
    parameter int N_LAYERS    = 6,
    parameter int COL_W       = 3,
    parameter int HOLD_FRAMES = 120,
    parameter int SCORE_W     = 4,
    parameter logic [COL_W-1:0] BG_COL   = 3'b000,
    parameter logic [COL_W-1:0] P1_COL   = 3'b010,
    parameter logic [COL_W-1:0] P2_COL   = 3'b100,
    parameter logic [COL_W-1:0] DRAW_COL = 3'b111
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      video_on,
    input  logic                      frame_start,
    input  logic [N_LAYERS-1:0]       layer_on,
    input  logic [N_LAYERS*COL_W-1:0] layer_col,
    input  logic                      end_on,
    input  logic                      p1_dead,
    input  logic                      p2_dead,
    output logic [COL_W-1:0]          rgb,
    output logic [1:0]                game_state,
    output logic                      round_restart,
    output logic [SCORE_W-1:0]        score1,
    output logic [SCORE_W-1:0]        score2
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WIN1 = 2'd1,
        ST_WIN2 = 2'd2,
        ST_DRAW = 2'd3
    } state_t;

    state_t              state_q;
    logic [COL_W-1:0]    rgb_q;
    logic                round_restart_q;
    logic [SCORE_W-1:0]  score1_q;
    logic [SCORE_W-1:0]  score2_q;
    logic                d1_q;
    logic                d2_q;
    logic [HOLD_W-1:0]   hold_q;

    logic [COL_W-1:0]    layer_pix;
    logic [COL_W-1:0]    overlay_col;
    logic                overlay_show;
    logic [COL_W-1:0]    rgb_d;
    logic                e1;
    logic                e2;

`ifdef LAYER_COMPOSITOR_BLINK_EN
    logic       blink_q;
    logic [3:0] blink_cnt_q;
`endif

    assign rgb           = rgb_q;
    assign game_state    = state_q;
    assign round_restart = round_restart_q;
    assign score1        = score1_q;
    assign score2        = score2_q;

    // A death asserted on the deciding cycle counts alongside the sticky flags.
    assign e1 = d1_q | p1_dead;
    assign e2 = d2_q | p2_dead;

    // Fixed-priority layer search: scanning downward lets the lowest index win.
    always_comb begin
        layer_pix = BG_COL;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_on[i]) begin
                layer_pix = layer_col[i*COL_W +: COL_W];
            end
        end
    end

    // Overlay colour for the current end state, gated by the glyph mask (and blink phase).
    always_comb begin
        case (state_q)
            ST_WIN1: overlay_col = P1_COL;
            ST_WIN2: overlay_col = P2_COL;
            default: overlay_col = DRAW_COL;
        endcase
`ifdef LAYER_COMPOSITOR_BLINK_EN
        overlay_show = end_on & ~blink_q;
`else
        overlay_show = end_on;
`endif
    end

    // Next pixel colour: blanking first, then layers in PLAY or overlay otherwise.
    always_comb begin
        if (!video_on) begin
            rgb_d = '0;
        end else if (state_q == ST_PLAY) begin
            rgb_d = layer_pix;
        end else begin
            rgb_d = overlay_show ? overlay_col : BG_COL;
        end
    end

    // Round state machine with registered pixel, restart pulse and scores.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_PLAY;
            rgb_q           <= '0;
            round_restart_q <= 1'b0;
            score1_q        <= '0;
            score2_q        <= '0;
            d1_q            <= 1'b0;
            d2_q            <= 1'b0;
            hold_q          <= '0;
`ifdef LAYER_COMPOSITOR_BLINK_EN
            blink_q         <= 1'b0;
            blink_cnt_q     <= '0;
`endif
        end else begin
            rgb_q           <= rgb_d;
            round_restart_q <= 1'b0;
            case (state_q)
                ST_PLAY: begin
                    if (frame_start && (e1 || e2)) begin
                        hold_q <= '0;
                        d1_q   <= 1'b0;
                        d2_q   <= 1'b0;
`ifdef LAYER_COMPOSITOR_BLINK_EN
                        blink_q     <= 1'b0;
                        blink_cnt_q <= '0;
`endif
                        if (e1 && e2) begin
                            state_q <= ST_DRAW;
                        end else if (e2) begin
                            state_q <= ST_WIN1;
                            if (score1_q != SCORE_MAX) begin
                                score1_q <= score1_q + 1'b1;
                            end
                        end else begin
                            state_q <= ST_WIN2;
                            if (score2_q != SCORE_MAX) begin
                                score2_q <= score2_q + 1'b1;
                            end
                        end
                    end else begin
                        d1_q <= e1;
                        d2_q <= e2;
                    end
                end
                default: begin
                    // Deaths are ignored here; only frame pulses advance the hold.
                    if (frame_start) begin
`ifdef LAYER_COMPOSITOR_BLINK_EN
                        blink_cnt_q <= blink_cnt_q + 4'd1;
                        if (blink_cnt_q == 4'd15) begin
                            blink_q <= ~blink_q;
                        end
`endif
                        if (hold_q == HOLD_LAST) begin
                            state_q         <= ST_PLAY;
                            hold_q          <= '0;
                            round_restart_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - directed self-checking bench for layer_compositor
module tb_layer_compositor;

    localparam int N_LAYERS    = 6;
    localparam int COL_W       = 3;
    localparam int HOLD_FRAMES = 3;
    localparam int SCORE_W     = 2;

    logic                      clk;
    logic                      reset;
    logic                      video_on;
    logic                      frame_start;
    logic [N_LAYERS-1:0]       layer_on;
    logic [N_LAYERS*COL_W-1:0] layer_col;
    logic                      end_on;
    logic                      p1_dead;
    logic                      p2_dead;
    logic [COL_W-1:0]          rgb;
    logic [1:0]                game_state;
    logic                      round_restart;
    logic [SCORE_W-1:0]        score1;
    logic [SCORE_W-1:0]        score2;

    int checks;
    int errors;

    layer_compositor #(
        .N_LAYERS   (N_LAYERS),
        .COL_W      (COL_W),
        .HOLD_FRAMES(HOLD_FRAMES),
        .SCORE_W    (SCORE_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .layer_on     (layer_on),
        .layer_col    (layer_col),
        .end_on       (end_on),
        .p1_dead      (p1_dead),
        .p2_dead      (p2_dead),
        .rgb          (rgb),
        .game_state   (game_state),
        .round_restart(round_restart),
        .score1       (score1),
        .score2       (score2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; video_on = 1'b0; frame_start = 1'b0; layer_on = '0;
        layer_col = '0; end_on = 1'b0; p1_dead = 1'b0; p2_dead = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b want 000", rgb); end
        checks++;
        if (game_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", game_state); end
        checks++;
        if (round_restart !== 1'b0) begin errors++; $display("FAIL reset_restart: got %b want 0", round_restart); end
        checks++;
        if (score1 !== 2'd0 || score2 !== 2'd0) begin errors++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score1, score2); end
    endtask

    task automatic test_priority();
        video_on = 1'b1;
        // layer5..0 colours: 011 010 100 001 101 110
        layer_col = {3'b011, 3'b010, 3'b100, 3'b001, 3'b101, 3'b110};
        layer_on = 6'b101100;
        tick();
        checks++;
        if (rgb !== 3'b001) begin errors++; $display("FAIL prio_l2: got %b want 001", rgb); end
        layer_on = 6'b000000;
        tick();
        checks++;
        if (rgb !== 3'b000) begin errors++; $display("FAIL prio_bg: got %b want 000", rgb); end
        layer_on = 6'b100000;
        tick();
        checks++;
        if (rgb !== 3'b011) begin errors++; $display("FAIL prio_l5: got %b want 011", rgb); end
        layer_on = 6'b111111;
        tick();
        checks++;
        if (rgb !== 3'b110) begin errors++; $display("FAIL prio_l0: got %b want 110", rgb); end
    endtask

    task automatic test_blanking();
        video_on = 1'b0;
        layer_on = 6'b000001;
        tick();
        checks++;
        if (rgb !== 3'b000) begin errors++; $display("FAIL blank: got %b want 000", rgb); end
        video_on = 1'b1;
    endtask

    task automatic test_single_win();
        layer_on = 6'b000100;
        p2_dead = 1'b1; tick(); p2_dead = 1'b0;
        tick(); tick();
        checks++;
        if (game_state !== 2'd0) begin errors++; $display("FAIL win_pre_state: got %0d want 0", game_state); end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++;
        if (game_state !== 2'd1) begin errors++; $display("FAIL win_state: got %0d want 1", game_state); end
        checks++;
        if (score1 !== 2'd1 || score2 !== 2'd0) begin errors++; $display("FAIL win_scores: got %0d/%0d want 1/0", score1, score2); end
        end_on = 1'b1;
        tick(); tick();
        checks++;
        if (rgb !== 3'b010) begin errors++; $display("FAIL win_overlay: got %b want 010", rgb); end
        end_on = 1'b0;
        tick();
        checks++;
        if (rgb !== 3'b000) begin errors++; $display("FAIL win_overlay_bg: got %b want 000", rgb); end
    endtask

    task automatic test_hold_restart();
        p1_dead = 1'b1; tick(); p1_dead = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            checks++;
            if (game_state !== 2'd1 || round_restart !== 1'b0) begin
                errors++; $display("FAIL hold_pulse%0d: got state %0d restart %b want 1 0", k, game_state, round_restart);
            end
            tick();
        end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++;
        if (game_state !== 2'd0) begin errors++; $display("FAIL restart_state: got %0d want 0", game_state); end
        checks++;
        if (round_restart !== 1'b1) begin errors++; $display("FAIL restart_pulse: got %b want 1", round_restart); end
        tick();
        checks++;
        if (round_restart !== 1'b0) begin errors++; $display("FAIL restart_width: got %b want 0", round_restart); end
        checks++;
        if (rgb !== 3'b001) begin errors++; $display("FAIL restart_layers: got %b want 001", rgb); end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++;
        if (game_state !== 2'd0) begin errors++; $display("FAIL ignored_death: got %0d want 0", game_state); end
        tick();
    endtask

    task automatic test_draw();
        p1_dead = 1'b1; tick(); tick();
        frame_start = 1'b1; p2_dead = 1'b1; tick();
        frame_start = 1'b0; p2_dead = 1'b0; p1_dead = 1'b0;
        checks++;
        if (game_state !== 2'd3) begin errors++; $display("FAIL draw_state: got %0d want 3", game_state); end
        checks++;
        if (score1 !== 2'd1 || score2 !== 2'd0) begin errors++; $display("FAIL draw_scores: got %0d/%0d want 1/0", score1, score2); end
        end_on = 1'b1; tick(); tick(); end_on = 1'b0;
        checks++;
        if (rgb !== 3'b111) begin errors++; $display("FAIL draw_overlay: got %b want 111", rgb); end
        for (int k = 0; k < HOLD_FRAMES; k++) pulse_frame();
        checks++;
        if (game_state !== 2'd0) begin errors++; $display("FAIL draw_return: got %0d want 0", game_state); end
    endtask

    task automatic test_saturation_reset();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if (score1 !== 2'd0) begin errors++; $display("FAIL sat_start: got %0d want 0", score1); end
        for (int w = 1; w <= 4; w++) begin
            p2_dead = 1'b1; tick(); p2_dead = 1'b0;
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            checks++;
            if (score1 !== ((w < 3) ? w[1:0] : 2'd3)) begin
                errors++; $display("FAIL sat_win%0d: got %0d want %0d", w, score1, (w < 3) ? w : 3);
            end
            if (w < 4) begin
                for (int k = 0; k < HOLD_FRAMES; k++) pulse_frame();
            end
        end
        pulse_frame(); pulse_frame();
        reset = 1'b1; frame_start = 1'b1; tick();
        reset = 1'b0; frame_start = 1'b0;
        checks++;
        if (score1 !== 2'd0 || game_state !== 2'd0) begin
            errors++; $display("FAIL reset_mid: got score %0d state %0d want 0 0", score1, game_state);
        end
        checks++;
        if (round_restart !== 1'b0) begin errors++; $display("FAIL reset_no_restart: got %b want 0", round_restart); end
        tick();
        checks++;
        if (round_restart !== 1'b0 || game_state !== 2'd0) begin
            errors++; $display("FAIL reset_after: got restart %b state %0d want 0 0", round_restart, game_state);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_priority();
        test_blanking();
        test_single_win();
        test_hold_restart();
        test_draw();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
